// File: rtl/deint_pkg.sv
// Shared constants and types for the deinterleaver input commutator.
package deint_pkg;

    localparam int unsigned NUM_BRANCH = 12;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BR_W       = 4;

    localparam logic [BR_W-1:0] FIRST_BRANCH = BR_W'(1);
    localparam logic [BR_W-1:0] LAST_BRANCH  = BR_W'(12);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/deint_branch_ctr.sv
// Branch pointer: counts 1..12 with wrap; a sync load jumps straight to branch 2.
module deint_branch_ctr
    import deint_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    output logic [BR_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= FIRST_BRANCH;
        end else if (load) begin
            count <= FIRST_BRANCH + BR_W'(1);
        end else if (inc) begin
            count <= (count == LAST_BRANCH) ? FIRST_BRANCH : count + BR_W'(1);
        end
    end

endmodule

// File: rtl/deint_commutator.sv
// Deinterleaver input commutator: hunts for packet sync, then distributes
// accepted bytes round-robin over twelve registered branch outputs.
module deint_commutator
    import deint_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    input  logic                  din_sync,
    output logic [DATA_W-1:0]     d_out1,
    output logic [DATA_W-1:0]     d_out2,
    output logic [DATA_W-1:0]     d_out3,
    output logic [DATA_W-1:0]     d_out4,
    output logic [DATA_W-1:0]     d_out5,
    output logic [DATA_W-1:0]     d_out6,
    output logic [DATA_W-1:0]     d_out7,
    output logic [DATA_W-1:0]     d_out8,
    output logic [DATA_W-1:0]     d_out9,
    output logic [DATA_W-1:0]     d_out10,
    output logic [DATA_W-1:0]     d_out11,
    output logic [DATA_W-1:0]     d_out12,
    output logic [NUM_BRANCH-1:0] br_valid,
    output logic [BR_W-1:0]       sel,
    output logic                  locked,
    output logic                  sync_err
);

    state_t                state;
    state_t                next_state;
    logic                  wr_en_c;
    logic [BR_W-1:0]       wr_idx_c;
    logic                  load_c;
    logic                  inc_c;
    logic                  err_c;
    logic [NUM_BRANCH-1:0] strobe_c;
    logic [DATA_W-1:0]     data_q [NUM_BRANCH];

    deint_branch_ctr u_branch_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_c),
        .inc   (inc_c),
        .count (sel)
    );

    // Next-state, write target and pointer control
    always_comb begin
        next_state = state;
        wr_en_c    = 1'b0;
        wr_idx_c   = sel;
        load_c     = 1'b0;
        inc_c      = 1'b0;
        err_c      = 1'b0;
        case (state)
            HUNT: begin
                if (din_valid && din_sync) begin
                    next_state = LOCKED;
                    wr_en_c    = 1'b1;
                    wr_idx_c   = FIRST_BRANCH;
                    load_c     = 1'b1;
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    wr_en_c = 1'b1;
                    if (din_sync) begin
                        wr_idx_c = FIRST_BRANCH;
                        load_c   = 1'b1;
                        err_c    = (sel != FIRST_BRANCH);
                    end else begin
                        inc_c = 1'b1;
                    end
                end
            end
            default: next_state = HUNT;
        endcase
    end

    // One-hot decode of the branch being written
    always_comb begin
        strobe_c = '0;
        for (int k = 0; k < NUM_BRANCH; k++) begin
            strobe_c[k] = wr_en_c && (wr_idx_c == BR_W'(k + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= HUNT;
            locked   <= 1'b0;
            br_valid <= '0;
            sync_err <= 1'b0;
            for (int k = 0; k < NUM_BRANCH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            state    <= next_state;
            locked   <= (next_state == LOCKED);
            br_valid <= strobe_c;
            sync_err <= err_c;
            for (int k = 0; k < NUM_BRANCH; k++) begin
                if (strobe_c[k]) begin
                    data_q[k] <= din;
                end
            end
        end
    end

    assign d_out1  = data_q[0];
    assign d_out2  = data_q[1];
    assign d_out3  = data_q[2];
    assign d_out4  = data_q[3];
    assign d_out5  = data_q[4];
    assign d_out6  = data_q[5];
    assign d_out7  = data_q[6];
    assign d_out8  = data_q[7];
    assign d_out9  = data_q[8];
    assign d_out10 = data_q[9];
    assign d_out11 = data_q[10];
    assign d_out12 = data_q[11];

endmodule

// File: tb/tb_deint_commutator.sv
// Bench for deint_commutator: directed scenarios plus random traffic checked
// against a byte-position reference model.
module tb_deint_commutator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_sync;
    logic [7:0]  d_obs [12];
    logic [11:0] br_valid;
    logic [3:0]  sel;
    logic        locked;
    logic        sync_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: position = bytes accepted since the last sync
    bit          m_locked;
    int unsigned m_pos;
    logic [7:0]  m_dout [12];
    logic [11:0] m_bv;
    logic        m_err;

    always #5 clk = ~clk;

    deint_commutator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_sync  (din_sync),
        .d_out1    (d_obs[0]),
        .d_out2    (d_obs[1]),
        .d_out3    (d_obs[2]),
        .d_out4    (d_obs[3]),
        .d_out5    (d_obs[4]),
        .d_out6    (d_obs[5]),
        .d_out7    (d_obs[6]),
        .d_out8    (d_obs[7]),
        .d_out9    (d_obs[8]),
        .d_out10   (d_obs[9]),
        .d_out11   (d_obs[10]),
        .d_out12   (d_obs[11]),
        .br_valid  (br_valid),
        .sel       (sel),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit v, input bit s, input logic [7:0] d);
        m_bv  = '0;
        m_err = 1'b0;
        if (!r) begin
            m_locked = 1'b0;
            m_pos    = 0;
            for (int k = 0; k < 12; k++) m_dout[k] = 8'h00;
        end else if (v && s) begin
            m_err    = m_locked && (m_pos % 12 != 0);
            m_dout[0] = d;
            m_bv     = 12'h001;
            m_pos    = 1;
            m_locked = 1'b1;
        end else if (v && m_locked) begin
            m_dout[m_pos % 12] = d;
            m_bv  = 12'(1) << (m_pos % 12);
            m_pos = m_pos + 1;
        end
    endtask

    task automatic compare_all();
        check("br_valid", 32'(br_valid), 32'(m_bv));
        check("sel", 32'(sel), m_locked ? 32'(m_pos % 12 + 1) : 32'd1);
        check("locked", 32'(locked), 32'(m_locked));
        check("sync_err", 32'(sync_err), 32'(m_err));
        for (int k = 0; k < 12; k++) begin
            check($sformatf("d_out%0d", k + 1), 32'(d_obs[k]), 32'(m_dout[k]));
        end
    endtask

    // One clock: drive inputs, let the edge pass, update model, compare
    task automatic step(input bit r, input bit v, input bit s, input logic [7:0] d);
        rst_n     = r;
        din_valid = v;
        din_sync  = s;
        din       = d;
        @(posedge clk);
        #1;
        model_update(r, v, s, d);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; din_valid = 1'b0; din_sync = 1'b0; din = '0;
        step(0, 0, 0, 8'h00);
        step(0, 1, 1, 8'hEE);

        // no sync: everything dropped
        for (int i = 0; i < 24; i++) step(1, 1, 0, 8'(i));

        // sync then fill all twelve branches
        step(1, 1, 1, 8'h47);
        for (int i = 1; i < 12; i++) step(1, 1, 0, 8'(i));
        check("sel_wrapped", 32'(sel), 32'd1);
        check("d_out12_fill", 32'(d_obs[11]), 32'h0B);

        // two aligned 204-byte packets
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 204; i++) step(1, 1, i == 0, 8'($urandom));
        end

        // misaligned sync at sel=5
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8'($urandom));
        check("sel_before_realign", 32'(sel), 32'd5);
        step(1, 1, 1, 8'hA5);
        check("realign_err", 32'(sync_err), 32'd1);
        step(1, 1, 0, 8'h3C);
        check("realign_next", 32'(br_valid), 32'h002);

        // alternating valid
        for (int i = 0; i < 40; i++) step(1, i % 2 == 0, 0, 8'($urandom));

        // reset mid-packet at sel=7
        step(1, 1, 1, 8'h11);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 8'($urandom));
        check("sel_before_rst", 32'(sel), 32'd7);
        step(0, 1, 0, 8'h99);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 8'($urandom));
        step(1, 1, 1, 8'h47);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0),
                 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
